// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, counter width and
// byte-to-word address handling.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W      = 4;
   localparam int WORD_SHIFT = 2;

   // A byte address is unusable if it is not word aligned or its word index
   // falls past the end of storage.
   function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
      return (addr[WORD_SHIFT-1:0] != '0) || ((addr >> WORD_SHIFT) >= depth);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port (master) and the
// memory responder (slave).
interface mem_responder_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_array.sv
// Single-port word storage with a registered read port; the read register
// clears on writes and rejected accesses so it can drive the response directly.
module mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (clr || (en && we)) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, answered after a fixed
// LATENCY with optional response backpressure and access-error flagging.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "mem_responder: LATENCY must be in 1..15");
   end

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              req_ready_q, req_ready_nxt;
   logic              resp_valid_q, resp_valid_nxt;
   logic              resp_err_q, resp_err_nxt;
   logic              accept, enter_resp;

   logic              we_q, err_q;
   logic [AW-1:0]     idx_q;
   logic [DATA_W-1:0] wdata_q;

   logic              acc_we, acc_err;
   logic [AW-1:0]     acc_idx;
   logic [DATA_W-1:0] acc_wdata;
   logic [DATA_W-1:0] arr_rdata;

   // With LATENCY=1 the accept edge is also the access edge, so the array
   // must see the live request rather than the latched copy.
   always_comb begin
      if (state == IDLE) begin
         acc_we    = bus.req_we;
         acc_err   = addr_bad(bus.req_addr, DEPTH);
         acc_idx   = bus.req_addr[WORD_SHIFT +: AW];
         acc_wdata = bus.req_wdata;
      end else begin
         acc_we    = we_q;
         acc_err   = err_q;
         acc_idx   = idx_q;
         acc_wdata = wdata_q;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      req_ready_nxt  = req_ready_q;
      resp_valid_nxt = resp_valid_q;
      resp_err_nxt   = resp_err_q;
      accept         = 1'b0;
      enter_resp     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept        = 1'b1;
               req_ready_nxt = 1'b0;
               if (LATENCY == 1) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = CNT_W'(LATENCY - 2);
               end
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_nxt      = IDLE;
               resp_valid_nxt = 1'b0;
               req_ready_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (enter_resp) begin
         resp_valid_nxt = 1'b1;
         resp_err_nxt   = acc_err;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         req_ready_q  <= req_ready_nxt;
         resp_valid_q <= resp_valid_nxt;
         resp_err_q   <= resp_err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         err_q   <= addr_bad(bus.req_addr, DEPTH);
         idx_q   <= bus.req_addr[WORD_SHIFT +: AW];
         wdata_q <= bus.req_wdata;
      end
   end

   // Gating with reset keeps a commit edge that coincides with reset from
   // touching storage.
   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk   (clk),
      .rst_n (reset),
      .en    (enter_resp && !acc_err && reset),
      .clr   (enter_resp && acc_err && reset),
      .we    (acc_we),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (arr_rdata)
   );

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three builds (LATENCY 2, 4 and 1) share
// clock and reset; index 0/1/2 selects the build in the helper arrays.
module tb_mem_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_responder_if #(.DATA_W(32)) if2 ();
   mem_responder_if #(.DATA_W(32)) if4 ();
   mem_responder_if #(.DATA_W(32)) if1 ();

   mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
   mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
   mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(if1));

   logic        dv  [3];
   logic        dwe [3];
   logic        drr [3];
   logic [31:0] dad [3];
   logic [31:0] dwd [3];
   logic        rr  [3];
   logic        rv  [3];
   logic        re  [3];
   logic [31:0] rd  [3];

   assign if2.req_valid = dv[0];  assign if2.req_we = dwe[0];  assign if2.resp_ready = drr[0];
   assign if2.req_addr  = dad[0]; assign if2.req_wdata = dwd[0];
   assign if4.req_valid = dv[1];  assign if4.req_we = dwe[1];  assign if4.resp_ready = drr[1];
   assign if4.req_addr  = dad[1]; assign if4.req_wdata = dwd[1];
   assign if1.req_valid = dv[2];  assign if1.req_we = dwe[2];  assign if1.resp_ready = drr[2];
   assign if1.req_addr  = dad[2]; assign if1.req_wdata = dwd[2];

   assign rr[0] = if2.req_ready; assign rv[0] = if2.resp_valid; assign re[0] = if2.resp_err; assign rd[0] = if2.resp_rdata;
   assign rr[1] = if4.req_ready; assign rv[1] = if4.resp_valid; assign re[1] = if4.resp_err; assign rd[1] = if4.resp_rdata;
   assign rr[2] = if1.req_ready; assign rv[2] = if1.resp_valid; assign re[2] = if1.resp_err; assign rd[2] = if1.resp_rdata;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction with resp_ready held high; lat counts cycles
   // from the accept cycle to the first cycle with resp_valid (99 = timeout).
   task automatic xact(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
      int n;
      chk($sformatf("idle_ready%0d", sel), rr[sel], 1);
      dv[sel] = 1'b1; dwe[sel] = we; dad[sel] = addr; dwd[sel] = wdata; drr[sel] = 1'b1;
      tick();
      dv[sel] = 1'b0;
      n = 1;
      while (!rv[sel] && n < 20) begin
         tick();
         n++;
      end
      rdata = rd[sel];
      err   = re[sel];
      lat   = rv[sel] ? n : 99;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      int          l;

      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         dv[s] = 1'b0; dwe[s] = 1'b0; drr[s] = 1'b0; dad[s] = '0; dwd[s] = '0;
      end
      tick();
      tick();
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("rst_ready%0d", s), rr[s], 1);
         chk($sformatf("rst_valid%0d", s), rv[s], 0);
         chk($sformatf("rst_rdata%0d", s), rd[s], 0);
         chk($sformatf("rst_err%0d", s), re[s], 0);
      end
      reset = 1'b1;
      tick();

      // LATENCY=2: first write, cycle by cycle
      dv[0] = 1'b1; dwe[0] = 1'b1; dad[0] = 32'h10; dwd[0] = 32'hDEADBEEF; drr[0] = 1'b1;
      chk("wr_accept_ready", rr[0], 1);
      tick();
      dv[0] = 1'b0;
      chk("wr_ready_drop", rr[0], 0);
      chk("wr_no_early_valid", rv[0], 0);
      tick();
      chk("wr_valid_lat2", rv[0], 1);
      chk("wr_err", re[0], 0);
      chk("wr_rdata_zero", rd[0], 0);
      tick();
      chk("wr_done_valid", rv[0], 0);
      chk("wr_done_ready", rr[0], 1);

      xact(0, 1'b1, 32'h0, 32'h00001111, d, e, l);
      chk("wr0_err", e, 0);
      chk("wr0_lat", l, 2);
      xact(0, 1'b0, 32'h10, 32'h0, d, e, l);
      chk("rd10_data", d, 32'hDEADBEEF);
      chk("rd10_err", e, 0);
      chk("rd10_lat", l, 2);
      xact(0, 1'b0, 32'h12, 32'h0, d, e, l);
      chk("rd_misalign_data", d, 0);
      chk("rd_misalign_err", e, 1);
      chk("rd_misalign_lat", l, 2);
      xact(0, 1'b1, 32'h400, 32'hBADBAD00, d, e, l);
      chk("wr_range_data", d, 0);
      chk("wr_range_err", e, 1);
      xact(0, 1'b0, 32'h0, 32'h0, d, e, l);
      chk("rd0_after_bad_wr", d, 32'h00001111);
      chk("rd0_err", e, 0);

      // LATENCY=2: response backpressure, stray requests ignored
      drr[0] = 1'b0;
      dv[0] = 1'b1; dwe[0] = 1'b0; dad[0] = 32'h10;
      tick();
      dv[0] = 1'b0;
      tick();
      chk("bp_valid", rv[0], 1);
      chk("bp_rdata", rd[0], 32'hDEADBEEF);
      for (int i = 0; i < 5; i++) begin
         dv[0] = (i % 2 == 0); dwe[0] = 1'b1; dad[0] = 32'h0; dwd[0] = 32'hFFFFFFFF;
         tick();
         chk($sformatf("bp_hold_valid%0d", i), rv[0], 1);
         chk($sformatf("bp_hold_rdata%0d", i), rd[0], 32'hDEADBEEF);
         chk($sformatf("bp_hold_ready%0d", i), rr[0], 0);
      end
      dv[0] = 1'b0;
      drr[0] = 1'b1;
      tick();
      chk("bp_release_valid", rv[0], 0);
      chk("bp_release_ready", rr[0], 1);
      tick();
      chk("bp_no_stray_valid", rv[0], 0);
      xact(0, 1'b0, 32'h0, 32'h0, d, e, l);
      chk("bp_stray_not_written", d, 32'h00001111);

      // LATENCY=4: reset in the middle of a write
      xact(1, 1'b1, 32'h24, 32'hA5A5A5A5, d, e, l);
      chk("l4_wr_lat", l, 4);
      xact(1, 1'b1, 32'h20, 32'h0, d, e, l);
      xact(1, 1'b0, 32'h24, 32'h0, d, e, l);
      chk("l4_rd24", d, 32'hA5A5A5A5);
      chk("l4_rd24_lat", l, 4);
      dv[1] = 1'b1; dwe[1] = 1'b1; dad[1] = 32'h20; dwd[1] = 32'h12345678; drr[1] = 1'b1;
      tick();
      dv[1] = 1'b0;
      tick();
      chk("l4_busy_ready", rr[1], 0);
      #2 reset = 1'b0;
      #1;
      chk("l4_async_ready", rr[1], 1);
      chk("l4_async_valid", rv[1], 0);
      chk("l4_async_rdata", rd[1], 0);
      chk("l4_async_err", re[1], 0);
      tick();
      reset = 1'b1;
      tick();
      xact(1, 1'b0, 32'h20, 32'h0, d, e, l);
      chk("l4_dropped_write", d, 32'h0);
      chk("l4_rd20_lat", l, 4);
      xact(0, 1'b0, 32'h10, 32'h0, d, e, l);
      chk("storage_survives_reset", d, 32'hDEADBEEF);

      // LATENCY=1 build
      xact(2, 1'b1, 32'h8, 32'hCAFEF00D, d, e, l);
      chk("l1_wr_lat", l, 1);
      chk("l1_wr_rdata", d, 0);
      xact(2, 1'b0, 32'h8, 32'h0, d, e, l);
      chk("l1_rd_data", d, 32'hCAFEF00D);
      chk("l1_rd_lat", l, 1);
      xact(2, 1'b0, 32'h3FC, 32'h0, d, e, l);
      chk("l1_last_word_err", e, 0);
      xact(2, 1'b0, 32'h401, 32'h0, d, e, l);
      chk("l1_bad_err", e, 1);
      chk("l1_bad_rdata", d, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory port: accepts one read or write request at a time from the control/datapath side and answers after a fixed, parameterised latency.
- Replaces the ideal single-cycle memory so the control FSM can be exercised against realistic wait states.
- Holds a word-addressed storage array and flags misaligned or out-of-range accesses.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 256, number of words in storage.
- LATENCY, 2, cycles from the accept cycle to the first cycle resp_valid is high. Legal range is 1..15; out-of-range is a fatal elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  requester takes the response.
- resp_rdata  output  DATA_W  read data; 0 for writes and errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset values (asynchronous, while reset=0): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter 0.
- Storage contents are not reset.
- All outputs are registered.
- States:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch we/addr/wdata.
    - LATENCY=1: go to RESP.
    - Otherwise: go to BUSY with counter=LATENCY-2.
    - req_ready drops in the following cycle.
  - BUSY: req_ready=0. Decrement the counter each edge. When the counter is 0, go to RESP on the next edge.
  - RESP: resp_valid=1. Hold rdata/err stable until an edge with resp_ready=1, then go to IDLE (resp_valid=0, req_ready=1).
- Timing: for a request accepted in cycle N, resp_valid is high from cycle N+LATENCY.
- The array is accessed on the edge entering RESP:
  - A write commits there.
  - A read samples the array there, so a read issued after a write returns the new data.
- Minimum request period is LATENCY+1 cycles when resp_ready is tied to 1.
- Error conditions: req_addr[1:0] != 0, or word index req_addr[31:2] >= DEPTH.
  - resp_err=1 and resp_rdata=0.
  - A write is suppressed (no array change).
  - Latency and handshake are unchanged.
- While the responder is in BUSY or RESP, req_valid is ignored. The requester holds req_valid until it sees req_ready=1 at an edge.
- Inputs other than resp_ready are not sampled outside IDLE.
- Reset mid-operation: the pending request is dropped. A write whose commit edge has not yet occurred never reaches the array. Outputs return to reset values immediately.
- resp_ready high while resp_valid=0 has no effect.

Decomposition:
- Shared package mem_pkg:
  - State encoding constants IDLE/BUSY/RESP (2-bit).
  - Counter width constant (4).
  - Word-address shift constant (2).
- One sub-module, mem_array: synchronous single-port DEPTH x DATA_W storage with write enable and registered read, instantiated once.
- FSM, counter and error check stay in mem_responder.

Test Plan:
- After reset release with LATENCY=2: write 0xDEADBEEF to addr 0x10, resp_ready=1 → req_ready=0 the next cycle; resp_valid high exactly 2 cycles after the accept cycle; resp_err=0, resp_rdata=0.
- Read addr 0x10 after the write above → resp_rdata=0xDEADBEEF, resp_err=0. Back-to-back read/write period is 3 cycles.
- Read addr 0x12 (misaligned), then write addr 0x400 (word 256 >= DEPTH) → both give resp_err=1, rdata=0. A later read of word 0 is unaffected by the bad write.
- Backpressure: resp_ready=0 for 5 cycles during a read of 0x10 → resp_valid and rdata stay constant. Deasserting and reasserting req_valid during this time is not accepted. Handshake completes on the first edge with resp_ready=1.
- Reset mid-operation: write 0x12345678 to 0x20, then assert reset in BUSY (LATENCY=4, after 1 cycle) → outputs return to reset values asynchronously. A subsequent read of 0x20 returns the old contents (pre-load 0x0 via a prior write).
- LATENCY=1 build: read accepted in cycle N → resp_valid in cycle N+1.
